fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the opcode decoder.
- Owns the PC and issues one request per instruction to instruction memory over a variable-latency handshake.
- Latches the returned word into an instruction register (IR) and presents opcode and field slices to decode/execute.
- Consumes the decoder's ldpc/halt outputs to redirect or stop fetching.

Parameters:
PC_W, 8, PC and instruction-memory address width
INSTR_W, 16, instruction width; fixed format opcode[15:12] rd[11:8] rs[7:4] rt[3:0], imm = [7:0]
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  one-cycle request pulse to instruction memory
imem_addr  out  PC_W  request address, equal to pc
imem_rdata  in  INSTR_W  returned instruction word
imem_valid  in  1  imem_rdata valid this cycle
stall  in  1  downstream busy; hold current instruction
ldpc  in  1  redirect request from decode/execute
target  in  PC_W  redirect address, valid with ldpc
halt  in  1  halt request from decode
resume  in  1  leave HALTED
opcode  out  4  IR[15:12] when instr_valid, else 4'b1111
rd  out  4  IR[11:8]
rs  out  4  IR[7:4]
rt  out  4  IR[3:0]
imm  out  8  IR[7:0]
instr_valid  out  1  IR holds an issued instruction
pc  out  PC_W  address of the instruction in IR / being fetched
halted  out  1  fetch stopped

Behaviour:
- Reset (async assert, sync release): state=FETCH, pc=RESET_PC, IR=0, imem_req=0, instr_valid=0, halted=0, opcode=4'b1111, rd/rs/rt/imm=0.
- Outputs are registered except opcode masking, imem_req and imem_addr, which decode state combinationally.
- Reset mid-operation discards any outstanding response. Memory shares rst, so no stale return follows.
- FETCH:
  - imem_req=1 and imem_addr=pc for exactly one cycle, then go to WAIT.
  - imem_valid is ignored in FETCH.
- WAIT:
  - imem_req=0.
  - On imem_valid=1: IR<=imem_rdata, go to ISSUE.
  - Unbounded wait; no timeout.
- ISSUE (instr_valid=1), priority order:
  1. stall=1: hold state, IR and pc; ldpc/halt ignored this cycle.
  2. halt=1: pc<=pc+1, go to HALTED. halt wins over a simultaneous ldpc.
  3. ldpc=1: pc<=target, go to FETCH.
  4. Otherwise: pc<=pc+1, go to FETCH.
- HALTED:
  - halted=1, instr_valid=0, imem_req=0.
  - resume=1 goes to FETCH using the current pc (HALT address + 1). resume is ignored in all other states.
- Sampling rules:
  - ldpc, target and halt are sampled only in ISSUE without stall.
  - instr_valid and halted are each 0 in FETCH/WAIT.
- Arithmetic:
  - pc+1 is modulo 2^PC_W (pc=PC_W'hFF with PC_W=8 wraps to 0x00).
  - target is taken unmodified.
- Throughput: minimum 3 cycles per instruction (FETCH, WAIT with 1-cycle latency, ISSUE).
- Masking: opcode reads 4'b1111 whenever instr_valid=0, an unused opcode the decoder maps to no side effects. Field outputs keep the stale IR value.

Test Plan:
- Reset then release, memory latency 1, rdata 16'h2105 at addr 0 -> imem_req at cycle 0 with addr 0; ISSUE at cycle 2 with opcode=2, rd=1, imm=0x05, pc=0; next request addr 1.
- Memory latency 3 at addr 1 (imem_valid withheld 2 extra cycles) -> instr_valid stays 0 and opcode=4'hF during the wait; IR captured only on the valid cycle.
- ISSUE with ldpc=1, target=0x40 -> next imem_addr=0x40. Simultaneous halt=1, ldpc=1 at pc=0x10 -> HALTED, pc=0x11, no further imem_req.
- HALTED held 5 cycles with resume=0 -> no requests; resume=1 -> FETCH at 0x11. resume pulsed during WAIT -> no effect.
- stall=1 for 4 cycles in ISSUE with ldpc=1 asserted throughout -> IR/pc unchanged, no redirect; stall drops with ldpc=0 -> sequential fetch at pc+1.
- pc=0xFF issued without redirect -> next fetch addr 0x00. rst asserted during WAIT -> immediate return to reset values, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch stage (master) and imem (slave).
interface fetch_unit_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over a
// variable-latency handshake, latches it into IR and presents decode fields.
module fetch_unit #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    imem,
  input  logic            stall,
  input  logic            ldpc,
  input  logic [PC_W-1:0] target,
  input  logic            halt,
  input  logic            resume,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs,
  output logic [3:0]      rt,
  output logic [7:0]      imm,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic [PC_W-1:0]    pc_inc;

  assign pc_inc = PC_W'(pc_q + PC_W'(1));

  // Next-state, PC and IR update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem.imem_valid) begin
          ir_d    = imem.imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          if (halt) begin
            pc_d    = pc_inc;
            state_d = S_HALTED;
          end else if (ldpc) begin
            pc_d    = target;
            state_d = S_FETCH;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        if (resume) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    instr_valid_d = (state_d == S_ISSUE);
    halted_d      = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= PC_W'(RESET_PC);
      ir_q          <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  // Request is held low while reset is asserted even though state sits in FETCH
  assign imem.imem_req  = (state_q == S_FETCH) && !rst;
  assign imem.imem_addr = pc_q;

  assign opcode      = instr_valid_q ? ir_q[15:12] : 4'hF;
  assign rd          = ir_q[11:8];
  assign rs          = ir_q[7:4];
  assign rt          = ir_q[3:0];
  assign imm         = ir_q[7:0];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule
